// File: rtl/rat_io_pkg.sv
// Shared types and constants for the RAT CPU I/O peripherals.
package rat_io_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVR   = 3;

    localparam logic [7:0] DEF_DATA_PORT_ID = 8'h40;
    localparam logic [7:0] DEF_STAT_PORT_ID = 8'h41;

endpackage

// File: rtl/rat_sync_fifo.sv
// Small first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees an entry in the same cycle.
module rat_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rat_uart_tx_port.sv
// RAT CPU output port: OUT writes queue bytes that are sent 8N1 on TX,
// IN from the status port reports {OVR, FULL, EMPTY, BUSY}.
module rat_uart_tx_port
    import rat_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] DATA_PORT_ID = DEF_DATA_PORT_ID,
    parameter logic [7:0] STAT_PORT_ID = DEF_STAT_PORT_ID
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_PORT,
    output logic       INTR,
    output logic       TX
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [2:0]     idx, idx_nxt;
    logic [7:0]     shift, shift_nxt;
    logic           tx_q, tx_nxt;
    logic           intr_q, intr_nxt;
    logic           ovr, ie;
    logic           wr_data, wr_stat;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic           cnt_end;

    assign wr_data = IO_STRB && (PORT_ID == DATA_PORT_ID);
    assign wr_stat = IO_STRB && (PORT_ID == STAT_PORT_ID);
    assign cnt_end = (cnt == CNT_MAX);
    assign TX      = tx_q;
    assign INTR    = intr_q;

    rat_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (wr_data),
        .pop     (fifo_pop),
        .din     (OUT_PORT),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        IN_PORT = 8'h00;
        if (PORT_ID == STAT_PORT_ID) begin
            IN_PORT[ST_OVR]   = ovr;
            IN_PORT[ST_FULL]  = fifo_full;
            IN_PORT[ST_EMPTY] = fifo_empty;
            IN_PORT[ST_BUSY]  = (state != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        intr_nxt  = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    tx_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = shift[0];
                    idx_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                        idx_nxt   = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_nxt = '0;
                    // Chain straight into the next frame so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dout;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        intr_nxt  = ie;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= 3'd0;
            tx_q   <= 1'b1;
            intr_q <= 1'b0;
            ovr    <= 1'b0;
            ie     <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            tx_q   <= tx_nxt;
            intr_q <= intr_nxt;
            if (wr_data && fifo_full && !fifo_pop) ovr <= 1'b1;
            else if (wr_stat && OUT_PORT[0])       ovr <= 1'b0;
            if (wr_stat) ie <= OUT_PORT[1];
        end
    end

    always_ff @(posedge CLK) begin
        shift <= shift_nxt;
    end

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Scoreboard bench for rat_uart_tx_port: written bytes are queued as expected
// frames and a TX line decoder pops and compares each completed frame.
module tb_rat_uart_tx_port;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic       IO_STRB = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic [7:0] IN_PORT;
    logic       INTR;
    logic       TX;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int intr_cnt = 0;
    int intr_cyc = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    rat_uart_tx_port #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .DATA_PORT_ID (8'h40),
        .STAT_PORT_ID (8'h41)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IO_STRB  (IO_STRB),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IN_PORT  (IN_PORT),
        .INTR     (INTR),
        .TX       (TX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller sits just after a rising edge; the strobe is sampled on the next edge.
    task automatic out_wr(input logic [7:0] pid, input logic [7:0] d);
        IO_STRB  = 1'b1;
        PORT_ID  = pid;
        OUT_PORT = d;
        @(posedge CLK);
        #1;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic rd_stat(output logic [7:0] v);
        PORT_ID = 8'h41;
        #1;
        v = IN_PORT;
        PORT_ID = 8'h00;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [7:0] v;
        v = 8'hFF;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #1;
            rd_stat(v);
            if (v[1:0] == 2'b10) break;
        end
        check(name, v[1:0], 2'b10);
    endtask

    task automatic wait_starts(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #1;
            if (start_q.size() >= n) break;
        end
        check(name, start_q.size(), n);
    endtask

    // TX decoder: 40 samples per frame, every bit must hold for exactly 4 cycles.
    initial begin : monitor
        logic [39:0] s;
        logic [7:0]  b;
        logic        shape_ok;
        bit          aborted;
        forever begin
            @(negedge CLK);
            if (RESET_N && TX === 1'b0) begin
                start_q.push_back(cyc);
                s = '0;
                aborted = 1'b0;
                for (int c = 1; c < 40; c++) begin
                    @(negedge CLK);
                    if (!RESET_N) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[c] = TX;
                end
                if (!aborted) begin
                    shape_ok = 1'b1;
                    for (int k = 0; k < 10; k++)
                        if (s[4*k +: 4] != 4'h0 && s[4*k +: 4] != 4'hF) shape_ok = 1'b0;
                    if (s[3:0] != 4'h0 || s[39:36] != 4'hF) shape_ok = 1'b0;
                    for (int k = 0; k < 8; k++) b[k] = s[4*(k+1) + 2];
                    check("frame_shape", shape_ok, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", b);
                    end else begin
                        check("tx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (INTR === 1'b1) begin
            intr_cnt <= intr_cnt + 1;
            intr_cyc <= cyc;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: stuck at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] v;
        #3 RESET_N = 1'b0;
        #1;
        check("reset_tx", TX, 1);
        check("reset_intr", INTR, 0);
        rd_stat(v);
        check("reset_status", v, 8'h02);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Reset in the middle of a frame with more bytes still queued
        out_wr(8'h40, 8'h5C);
        out_wr(8'h40, 8'hB7);
        out_wr(8'h40, 8'hC8);
        repeat (10) @(posedge CLK);
        #1;
        rd_stat(v);
        check("pre_reset_status", v, 8'h01);
        check("pre_reset_tx", TX, 0);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_tx", TX, 1);
        check("async_reset_intr", INTR, 0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        rd_stat(v);
        check("post_reset_status", v, 8'h02);
        repeat (60) @(posedge CLK);
        #1;
        check("post_reset_tx_idle", TX, 1);
        rd_stat(v);
        check("post_reset_still_empty", v, 8'h02);

        // Single byte latency and frame length
        start_q.delete();
        exp_q.push_back(8'hA5);
        out_wr(8'h40, 8'hA5);
        check("latency_tx_high", TX, 1);
        @(posedge CLK);
        #1;
        check("latency_tx_low", TX, 0);
        repeat (39) @(posedge CLK);
        #1;
        rd_stat(v);
        check("single_busy_last_cycle", v, 8'h03);
        @(posedge CLK);
        #1;
        rd_stat(v);
        check("single_idle", v, 8'h02);
        check("single_drained", exp_q.size(), 0);

        // Back-to-back frames
        start_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        out_wr(8'h40, 8'h3C);
        out_wr(8'h40, 8'h81);
        out_wr(8'h40, 8'h7E);
        wait_starts("b2b_starts", 3, 150);
        rd_stat(v);
        check("b2b_empty_busy", v, 8'h03);
        if (start_q.size() >= 3) begin
            check("b2b_gap_1", start_q[1] - start_q[0], 40);
            check("b2b_gap_2", start_q[2] - start_q[1], 40);
        end
        wait_idle("b2b_idle", 100);
        check("b2b_drained", exp_q.size(), 0);

        // Overrun: sixth write is dropped
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        out_wr(8'h40, 8'h11);
        out_wr(8'h40, 8'h22);
        out_wr(8'h40, 8'h33);
        out_wr(8'h40, 8'h44);
        out_wr(8'h40, 8'h55);
        out_wr(8'h40, 8'h66);
        rd_stat(v);
        check("ovr_status", v, 8'h0D);
        PORT_ID = 8'h40;
        #1;
        check("in_port_data_id", IN_PORT, 8'h00);
        PORT_ID = 8'h42;
        #1;
        check("in_port_other_id", IN_PORT, 8'h00);
        PORT_ID = 8'h00;
        @(posedge CLK);
        #1;
        out_wr(8'h41, 8'h01);
        rd_stat(v);
        check("ovr_cleared", v, 8'h05);
        wait_idle("ovr_idle", 300);
        check("ovr_drained", exp_q.size(), 0);

        // Interrupt on drain, enabled then disabled
        @(posedge CLK);
        #1;
        start_q.delete();
        out_wr(8'h41, 8'h02);
        intr_cnt = 0;
        exp_q.push_back(8'hC3);
        out_wr(8'h40, 8'hC3);
        repeat (60) @(posedge CLK);
        #1;
        check("intr_pulses_ie1", intr_cnt, 1);
        check("intr_frame_seen", start_q.size(), 1);
        if (start_q.size() > 0) check("intr_timing", intr_cyc - start_q[0], 40);
        out_wr(8'h41, 8'h00);
        intr_cnt = 0;
        exp_q.push_back(8'h96);
        out_wr(8'h40, 8'h96);
        repeat (60) @(posedge CLK);
        #1;
        check("intr_pulses_ie0", intr_cnt, 0);
        check("intr_drained", exp_q.size(), 0);

        // Unmapped port write is ignored
        out_wr(8'h42, 8'h99);
        rd_stat(v);
        check("decode_status", v, 8'h02);
        repeat (50) @(posedge CLK);
        #1;
        check("decode_tx_idle", TX, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
